// File: rtl/bit_decompose_pkg.sv
// Shared constants and FSM state type for the bit_decompose block.
package bit_decompose_pkg;

  localparam int unsigned MASK_W = 32;
  localparam int unsigned IDX_W  = $clog2(MASK_W);

  typedef enum logic [0:0] {
    IDLE,
    EMIT
  } state_e;

endpackage

// File: rtl/lsb_enc.sv
// Combinational lowest-set-bit encoder: index of the lowest 1 plus an any-set flag.
module lsb_enc
  import bit_decompose_pkg::*;
#(
  parameter int unsigned WIDTH = MASK_W,
  parameter int unsigned IDXW  = IDX_W
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDXW-1:0]  idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    idx = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDXW'(i);
    end
    any = |vec;
  end

endmodule

// File: rtl/bit_decompose.sv
// Splits a captured bit mask into one beat per set bit, lowest index first,
// with a valid/ready handshake on both sides.
module bit_decompose
  import bit_decompose_pkg::*;
#(
  parameter int unsigned WIDTH = MASK_W,
  parameter int unsigned IDXW  = IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             out_zero,
  output logic             busy
);

  if (WIDTH != MASK_W || IDXW != $clog2(WIDTH)) begin : gen_param_err
    $error("bit_decompose: only WIDTH=32 with IDXW=5 is supported");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] rem_clr;
  logic [IDXW-1:0]  lsb_idx;
  logic             lsb_any;
  logic             single;

  lsb_enc #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_lsb_enc (
    .vec (rem_q),
    .idx (lsb_idx),
    .any (lsb_any)
  );

  // rem with its lowest set bit cleared; zero means this beat is the last.
  assign rem_clr = rem_q & (rem_q - WIDTH'(1));
  assign single  = (rem_clr == '0);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_zero  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          rem_d   = in_mask;
          state_d = EMIT;
        end
      end
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_idx   = lsb_idx;
        out_last  = single;
        // rem can only be zero in EMIT when the captured mask itself was zero.
        out_zero  = ~lsb_any;
        if (out_ready) begin
          rem_d = rem_clr;
          if (single) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

endmodule
